// File: rtl/dsp_boot_loader_pkg.sv
// Shared definitions for the DSP boot loader: the SRAM/register widths, the
// sequencer state encoding, the default reset-hold length and a width helper
// for the bank-select field.
package dsp_boot_loader_pkg;

    localparam int SRAM_ADDR_LEN  = 15;
    localparam int REG_WORD_LEN   = 16;
    localparam int BL_HOLD_CYCLES = 4;

    typedef enum logic [1:0] {
        BL_IDLE = 2'd0,
        BL_LOAD = 2'd1,
        BL_HOLD = 2'd2,
        BL_RUN  = 2'd3
    } bl_state_t;

    // Bank-select width; a single bank still gets a one-bit field.
    function automatic int bank_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/dsp_boot_loader_addr_counter.sv
// bl_addr_counter: write-address up-counter (wraps modulo 2^ADDR_W) paired with
// a remaining-word down-counter. 'last' flags that the next step consumes the
// final word of the load.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture base/len (takes priority over step)
//   base, len : first address and word count
//   step      : one word accepted
//   addr      : address for the word currently being accepted
//   last      : remaining == 1
module bl_addr_counter #(
    parameter int ADDR_W = 15,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [LEN_W-1:0] remaining_r;

    // Address and remaining-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr        <= {ADDR_W{1'b0}};
            remaining_r <= {LEN_W{1'b0}};
        end else if (load) begin
            addr        <= base;
            remaining_r <= len;
        end else if (step) begin
            addr        <= addr + ADDR_W'(1);
            remaining_r <= remaining_r - LEN_W'(1);
        end else begin
            addr        <= addr;
            remaining_r <= remaining_r;
        end
    end

    assign last = (remaining_r == LEN_W'(1));

endmodule

// File: rtl/dsp_boot_loader.sv
// dsp_boot_loader: preloads one of NUM_BANKS data SRAM banks from a
// valid/ready word stream and keeps the DSP core in reset until HOLD_CYCLES
// cycles after the final accepted word.
//   clk, rst                 : clock, synchronous active-high reset
//   start, cfg_bank/base/len : single-cycle load request and its configuration
//   in_valid/in_ready/in_data: word stream (in_ready is high throughout LOAD)
//   wr_en/wr_addr/wr_data    : registered SRAM write port, one cycle after accept
//   core_rst                 : DSP core reset, low only in RUN
//   busy, done, err          : LOAD|HOLD, first RUN cycle, rejected start
module dsp_boot_loader
    import dsp_boot_loader_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_LEN,
    parameter int DATA_W      = REG_WORD_LEN,
    parameter int NUM_BANKS   = 2,
    parameter int LEN_W       = 16,
    parameter int HOLD_CYCLES = BL_HOLD_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [bank_w(NUM_BANKS)-1:0] cfg_bank,
    input  logic [ADDR_W-1:0]            cfg_base,
    input  logic [LEN_W-1:0]             cfg_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic [NUM_BANKS-1:0]         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [DATA_W-1:0]            wr_data,
    output logic                         core_rst,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int BANK_W   = bank_w(NUM_BANKS);
    localparam int LIMIT_W  = BANK_W + 1;
    localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
    // One extra bit so a power-of-two bank count is representable.
    localparam logic [LIMIT_W-1:0] BANK_LIMIT = LIMIT_W'(NUM_BANKS);
    localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(HOLD_CYCLES - 1);

    bl_state_t            state_r;
    logic [BANK_W-1:0]    bank_r;
    logic [HOLD_W-1:0]    hold_cnt_r;
    logic [ADDR_W-1:0]    addr_s;
    logic                 last_s;
    logic                 accept_s;
    logic                 bank_ok_s;
    logic                 can_start_s;
    logic                 start_ok_s;
    logic [NUM_BANKS-1:0] onehot_s;

    assign in_ready = (state_r == BL_LOAD);

    // Start qualification, stream handshake and bank decode.
    always_comb begin
        bank_ok_s   = ({1'b0, cfg_bank} < BANK_LIMIT);
        can_start_s = (state_r == BL_IDLE) || (state_r == BL_RUN);
        start_ok_s  = start && bank_ok_s && can_start_s;
        accept_s    = in_valid && in_ready;
        onehot_s    = {NUM_BANKS{1'b0}};
        for (int i = 0; i < NUM_BANKS; i++) begin
            onehot_s[i] = (bank_r == BANK_W'(i));
        end
    end

    bl_addr_counter #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_counter (
        .clk  (clk),
        .rst  (rst),
        .load (start_ok_s),
        .base (cfg_base),
        .len  (cfg_len),
        .step (accept_s),
        .addr (addr_s),
        .last (last_s)
    );

    // Sequencer FSM with registered write port, hold timer and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= BL_IDLE;
            bank_r     <= {BANK_W{1'b0}};
            hold_cnt_r <= {HOLD_W{1'b0}};
            core_rst   <= 1'b1;
            wr_en      <= {NUM_BANKS{1'b0}};
            wr_addr    <= {ADDR_W{1'b0}};
            wr_data    <= {DATA_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            // Write port: exactly one cycle after each accept, idle otherwise.
            if (accept_s) begin
                wr_en   <= onehot_s;
                wr_addr <= addr_s;
                wr_data <= in_data;
            end else begin
                wr_en <= {NUM_BANKS{1'b0}};
            end

            case (state_r)
                BL_IDLE, BL_RUN: begin
                    if (start && bank_ok_s) begin
                        // Fresh load or reload: core goes back into reset.
                        bank_r   <= cfg_bank;
                        core_rst <= 1'b1;
                        busy     <= 1'b1;
                        if (cfg_len != {LEN_W{1'b0}}) begin
                            state_r <= BL_LOAD;
                        end else begin
                            state_r    <= BL_HOLD;
                            hold_cnt_r <= HOLD_INIT;
                        end
                    end else if (start) begin
                        err <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                BL_LOAD: begin
                    if (start) begin
                        err <= 1'b1;
                    end
                    if (accept_s && last_s) begin
                        state_r    <= BL_HOLD;
                        hold_cnt_r <= HOLD_INIT;
                    end
                end
                BL_HOLD: begin
                    if (start) begin
                        err <= 1'b1;
                    end
                    if (hold_cnt_r == {HOLD_W{1'b0}}) begin
                        state_r  <= BL_RUN;
                        core_rst <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
                    end
                end
                default: begin
                    state_r  <= BL_IDLE;
                    core_rst <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_boot_loader.sv
// Self-checking bench for dsp_boot_loader. Three banks are used so that an
// out-of-range bank index (3) is expressible on the two-bit cfg_bank field.
module tb_dsp_boot_loader;

    localparam int ADDR_W      = 15;
    localparam int DATA_W      = 16;
    localparam int NUM_BANKS   = 3;
    localparam int LEN_W       = 16;
    localparam int HOLD_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  cfg_bank;
    logic [14:0] cfg_base;
    logic [15:0] cfg_len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  wr_en;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    dsp_boot_loader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_BANKS   (NUM_BANKS),
        .LEN_W       (LEN_W),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_bank (cfg_bank),
        .cfg_base (cfg_base),
        .cfg_len  (cfg_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  en;
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [1:0]  bank;
        logic [14:0] base;
        logic [15:0] len;
        logic [7:0]  pat;      // in_valid pattern, bit i used on cycle i mod 8
        logic [2:0]  exp_en;
        logic [14:0] exp_last;
    } vec_t;

    wr_t         wlog[$];
    logic [15:0] mem [int];
    int done_cnt  = 0;
    int err_cnt   = 0;
    int multi_hot = 0;
    int n_pass    = 0;
    int n_total   = 0;

    // SRAM model and event counters, sampled on the write edge.
    always @(posedge clk) begin
        if (wr_en != 3'b000) begin
            wlog.push_back('{wr_en, wr_addr, wr_data});
            if ($countones(wr_en) != 1) multi_hot++;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (wr_en[b]) mem[b * 65536 + int'(wr_addr)] = wr_data;
            end
        end
        if (done) done_cnt++;
        if (err)  err_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] mem_rd(input int b, input logic [14:0] a);
        int k;
        k = b * 65536 + int'(a);
        return mem.exists(k) ? mem[k] : 16'hDEAD;
    endfunction

    function automatic logic [15:0] data_of(input int row, input int idx);
        return 16'hA000 + 16'(row * 256) + 16'(idx);
    endfunction

    // Called on a negedge; returns on the next negedge with start released.
    task automatic do_start(input logic [1:0] b, input logic [14:0] base, input logic [15:0] len);
        start    = 1'b1;
        cfg_bank = b;
        cfg_base = base;
        cfg_len  = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int c;
        c = 0;
        while (done_cnt == d0 && c < budget) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic run_row(input vec_t v, input int row);
        int idx, cyc, d0, e0;
        bit busy_ok, rdy_ok;
        logic [14:0] ea;
        idx = 0; cyc = 0; busy_ok = 1'b1; rdy_ok = 1'b1;
        wlog.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        do_start(v.bank, v.base, v.len);
        check($sformatf("row%0d_core_rst_on_start", row), 32'(core_rst), 32'd1);
        while (done_cnt == d0 && cyc < 300) begin
            if (idx < int'(v.len)) begin
                in_valid = v.pat[cyc % 8];
                in_data  = data_of(row, idx);
                if (!busy) busy_ok = 1'b0;
                if (in_valid && in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
            if (v.len == 16'd0 && in_ready) rdy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check($sformatf("row%0d_done", row), 32'(done_cnt), 32'(d0 + 1));
        check($sformatf("row%0d_nwrites", row), 32'(wlog.size()), 32'(v.len));
        for (int k = 0; k < wlog.size() && k < int'(v.len); k++) begin
            ea = v.base + 15'(k);
            check($sformatf("row%0d_w%0d_en", row, k),   32'(wlog[k].en),   32'(v.exp_en));
            check($sformatf("row%0d_w%0d_addr", row, k), 32'(wlog[k].addr), 32'(ea));
            check($sformatf("row%0d_w%0d_data", row, k), 32'(wlog[k].data), 32'(data_of(row, k)));
        end
        if (v.len != 16'd0) begin
            check($sformatf("row%0d_last_addr", row), 32'(wlog[wlog.size() - 1].addr), 32'(v.exp_last));
            check($sformatf("row%0d_sram", row), 32'(mem_rd(int'(v.bank), v.exp_last)),
                  32'(data_of(row, int'(v.len) - 1)));
        end else begin
            check($sformatf("row%0d_hold_len", row), 32'(cyc), 32'(HOLD_CYCLES + 1));
            check($sformatf("row%0d_ready_low", row), 32'(rdy_ok), 32'd1);
        end
        check($sformatf("row%0d_busy", row), 32'(busy_ok), 32'd1);
        check($sformatf("row%0d_no_err", row), 32'(err_cnt), 32'(e0));
        check($sformatf("row%0d_core_run", row), 32'(core_rst), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check($sformatf("row%0d_done_once", row), 32'(done_cnt), 32'(d0 + 1));
    endtask

    initial begin
        vec_t vecs[6];
        int d0, e0;

        vecs[0] = '{2'd0, 15'h0000, 16'd1, 8'hFF, 3'b001, 15'h0000};
        vecs[1] = '{2'd1, 15'h0100, 16'd4, 8'hED, 3'b010, 15'h0103};
        vecs[2] = '{2'd0, 15'h7FFE, 16'd3, 8'hFF, 3'b001, 15'h0000};
        vecs[3] = '{2'd2, 15'h0055, 16'd0, 8'hFF, 3'b100, 15'h0055};
        vecs[4] = '{2'd2, 15'h1234, 16'd5, 8'h66, 3'b100, 15'h1238};
        vecs[5] = '{2'd0, 15'h7FFF, 16'd2, 8'hAA, 3'b001, 15'h0000};

        rst = 1'b1; start = 1'b0; cfg_bank = 2'd0; cfg_base = 15'h0;
        cfg_len = 16'd0; in_valid = 1'b0; in_data = 16'h0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en",    32'(wr_en),    32'd0);
        check("rst_wr_addr",  32'(wr_addr),  32'd0);
        check("rst_wr_data",  32'(wr_data),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Invalid bank from IDLE.
        wlog.delete();
        do_start(2'd3, 15'h0010, 16'd2);
        check("inv_idle_err",      32'(err),      32'd1);
        check("inv_idle_core_rst", 32'(core_rst), 32'd1);
        check("inv_idle_busy",     32'(busy),     32'd0);
        check("inv_idle_ready",    32'(in_ready), 32'd0);
        @(negedge clk);
        check("inv_idle_err_pulse", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        check("inv_idle_no_write", 32'(wlog.size()), 32'd0);

        // Single word: exact write latency and reset-release timing.
        wlog.delete();
        do_start(2'd0, 15'h0000, 16'd1);
        check("sw_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 16'd25;
        @(negedge clk);
        in_valid = 1'b0;
        check("sw_wr_en",   32'(wr_en),    32'b001);
        check("sw_wr_addr", 32'(wr_addr),  32'd0);
        check("sw_wr_data", 32'(wr_data),  32'd25);
        check("sw_ready_drop", 32'(in_ready), 32'd0);
        for (int k = 2; k <= HOLD_CYCLES; k++) begin
            @(negedge clk);
            check($sformatf("sw_hold%0d_core_rst", k), 32'(core_rst), 32'd1);
        end
        @(negedge clk);
        check("sw_core_rst_fall", 32'(core_rst), 32'd0);
        check("sw_done", 32'(done), 32'd1);
        @(negedge clk);
        check("sw_done_pulse", 32'(done), 32'd0);
        check("sw_done_cnt",   32'(done_cnt), 32'd1);
        check("sw_sram",       32'(mem_rd(0, 15'h0000)), 32'd25);
        check("sw_nwrites",    32'(wlog.size()), 32'd1);

        // Invalid bank while in RUN: err, core stays released.
        do_start(2'd3, 15'h0000, 16'd1);
        check("inv_run_err",      32'(err),      32'd1);
        check("inv_run_core_rst", 32'(core_rst), 32'd0);
        @(negedge clk);
        check("inv_run_still", 32'(core_rst), 32'd0);

        // Table-driven loads, each a reload from RUN.
        for (int r = 0; r < 5; r++) run_row(vecs[r], r);

        // start during LOAD is rejected and the load completes unchanged.
        wlog.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        do_start(2'd1, 15'h0040, 16'd3);
        in_valid = 1'b1; in_data = 16'hB000;
        @(negedge clk);
        in_data = 16'hB001;
        start = 1'b1; cfg_bank = 2'd0; cfg_base = 15'h0999; cfg_len = 16'd7;
        @(negedge clk);
        start = 1'b0; in_data = 16'hB002;
        check("bs_err", 32'(err), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(d0, 40);
        check("bs_done",    32'(done_cnt), 32'(d0 + 1));
        check("bs_err_cnt", 32'(err_cnt),  32'(e0 + 1));
        check("bs_nwrites", 32'(wlog.size()), 32'd3);
        for (int k = 0; k < wlog.size() && k < 3; k++) begin
            check($sformatf("bs_w%0d", k), 32'(wlog[k]),
                  32'({3'b010, 15'h0040 + 15'(k), 16'hB000 + 16'(k)}));
        end

        // Reset after two of five words.
        wlog.delete();
        d0 = done_cnt;
        do_start(2'd0, 15'h0200, 16'd5);
        in_valid = 1'b1; in_data = 16'hC000;
        @(negedge clk);
        in_data = 16'hC001;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_core_rst", 32'(core_rst), 32'd1);
        check("mr_busy",     32'(busy),     32'd0);
        check("mr_ready",    32'(in_ready), 32'd0);
        check("mr_wr_en",    32'(wr_en),    32'd0);
        repeat (10) @(negedge clk);
        check("mr_no_done",  32'(done_cnt), 32'(d0));
        check("mr_nwrites",  32'(wlog.size()), 32'd2);
        check("mr_sram0",    32'(mem_rd(0, 15'h0200)), 32'hC000);
        check("mr_sram1",    32'(mem_rd(0, 15'h0201)), 32'hC001);
        check("mr_core_held", 32'(core_rst), 32'd1);

        // Fresh load from IDLE after the reset, wrapping at the top address.
        run_row(vecs[5], 5);

        check("wr_en_onehot", 32'(multi_hot), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
